// File: rtl/ask_frame_ctrl_if.sv
// Payload delivery and frame status bundle between the ASK frame
// sequencer (master) and the downstream byte consumer (slave).
interface ask_frame_ctrl_if #(
    parameter int PACKLEN = 8
);
    logic [PACKLEN-1:0] data;
    logic               data_valid;
    logic               data_ready;
    logic               frame_done;
    logic [2:0]         frame_err;

    modport master (
        output data,
        output data_valid,
        output frame_done,
        output frame_err,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        input  frame_done,
        input  frame_err,
        output data_ready
    );
endinterface

// File: rtl/ask_frame_ctrl.sv
// Frame-level sequencer for the ASK receive path.
// Arms the preamble correlator, restarts the symbol clock on preamble lock,
// gates the syncword correlator, then assembles a length byte, LEN payload
// bytes and an XOR checksum byte. Payload bytes leave over a valid/ready
// port; one frame_done pulse with a held error code closes each frame.
module ask_frame_ctrl #(
    parameter int PACKLEN      = 8,
    parameter int MAX_LEN      = 16,
    parameter int SYNC_TIMEOUT = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             preamble_hit,
    input  logic             sync_hit,
    input  logic             symb_tick,
    input  logic             bit_in,
    output logic             prm_en,
    output logic             sync_en,
    output logic             resync,
    ask_frame_ctrl_if.master bus
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int BW = (PACKLEN > 1) ? $clog2(PACKLEN) : 1;

    localparam logic [TW-1:0]      TMO_LIMIT = TW'(SYNC_TIMEOUT);
    localparam logic [BW-1:0]      BIT_LAST  = BW'(PACKLEN - 1);
    localparam logic [PACKLEN-1:0] LEN_MAX   = PACKLEN'(MAX_LEN);
    localparam logic [PACKLEN-1:0] BYTE_ZERO = {PACKLEN{1'b0}};
    localparam logic [PACKLEN-1:0] BYTE_ONE  = PACKLEN'(1);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_BADLEN  = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_t;

    // Running XOR checksum over the length byte and every payload byte.
    function automatic logic [PACKLEN-1:0] csum_update(
        input logic [PACKLEN-1:0] acc,
        input logic [PACKLEN-1:0] value
    );
        return acc ^ value;
    endfunction

    // Bits arrive MSB first, so each new symbol enters at the LSB.
    function automatic logic [PACKLEN-1:0] shift_in(
        input logic [PACKLEN-1:0] sr,
        input logic               b
    );
        return {sr[PACKLEN-2:0], b};
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [TW-1:0]      tmo_r;
    logic [TW-1:0]      tmo_s;
    logic [TW-1:0]      tmo_inc_s;
    logic [BW-1:0]      bit_cnt_r;
    logic [BW-1:0]      bit_cnt_s;
    logic [PACKLEN-1:0] shreg_r;
    logic [PACKLEN-1:0] shreg_s;
    logic [PACKLEN-1:0] len_r;
    logic [PACKLEN-1:0] len_s;
    logic [PACKLEN-1:0] rem_r;
    logic [PACKLEN-1:0] rem_s;
    logic [PACKLEN-1:0] csum_r;
    logic [PACKLEN-1:0] csum_s;
    logic [PACKLEN-1:0] data_r;
    logic [PACKLEN-1:0] data_s;
    logic               data_valid_r;
    logic               data_valid_s;
    logic               frame_done_r;
    logic               frame_done_s;
    logic [2:0]         frame_err_r;
    logic [2:0]         frame_err_s;
    logic               resync_r;
    logic               resync_s;
    logic               prm_en_r;
    logic               sync_en_r;
    logic [PACKLEN-1:0] byte_s;
    logic               byte_end_s;

    // The byte as it stands once the current symbol is shifted in.
    assign byte_s     = shift_in(shreg_r, bit_in);
    assign byte_end_s = symb_tick && (bit_cnt_r == BIT_LAST);
    assign tmo_inc_s  = (tmo_r == TMO_LIMIT) ? tmo_r : (tmo_r + TW'(1));

    assign prm_en         = prm_en_r;
    assign sync_en        = sync_en_r;
    assign resync         = resync_r;
    assign bus.data       = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_done = frame_done_r;
    assign bus.frame_err  = frame_err_r;

    // State register for the frame sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath logic; abort overrides every other event.
    always_comb begin
        state_s      = state_r;
        tmo_s        = tmo_r;
        bit_cnt_s    = bit_cnt_r;
        shreg_s      = shreg_r;
        len_s        = len_r;
        rem_s        = rem_r;
        csum_s       = csum_r;
        data_s       = data_r;
        data_valid_s = (data_valid_r && bus.data_ready) ? 1'b0 : data_valid_r;
        frame_done_s = 1'b0;
        frame_err_s  = frame_err_r;
        resync_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (preamble_hit) begin
                    state_s  = ST_HUNT;
                    resync_s = 1'b1;
                    tmo_s    = {TW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HUNT: begin
                if (sync_hit) begin
                    // A coincident tick is deliberately not counted.
                    state_s   = ST_LEN;
                    bit_cnt_s = {BW{1'b0}};
                    csum_s    = BYTE_ZERO;
                    shreg_s   = BYTE_ZERO;
                end else if (preamble_hit) begin
                    resync_s = 1'b1;
                    tmo_s    = {TW{1'b0}};
                end else if (symb_tick) begin
                    tmo_s = tmo_inc_s;
                    if (tmo_inc_s == TMO_LIMIT) begin
                        state_s      = ST_IDLE;
                        frame_done_s = 1'b1;
                        frame_err_s  = ERR_TIMEOUT;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else begin
                    state_s = ST_HUNT;
                end
            end

            ST_LEN: begin
                if (symb_tick) begin
                    shreg_s = byte_s;
                    if (byte_end_s) begin
                        bit_cnt_s = {BW{1'b0}};
                        len_s     = byte_s;
                        csum_s    = byte_s;
                        if ((byte_s == BYTE_ZERO) || (byte_s > LEN_MAX)) begin
                            state_s      = ST_IDLE;
                            frame_done_s = 1'b1;
                            frame_err_s  = ERR_BADLEN;
                        end else begin
                            state_s = ST_PAYLOAD;
                            rem_s   = byte_s;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end

            ST_PAYLOAD: begin
                if (symb_tick) begin
                    shreg_s = byte_s;
                    if (byte_end_s) begin
                        bit_cnt_s = {BW{1'b0}};
                        if (data_valid_r && !bus.data_ready) begin
                            // Previous byte still unclaimed: the frame is lost.
                            state_s      = ST_IDLE;
                            data_valid_s = 1'b0;
                            frame_done_s = 1'b1;
                            frame_err_s  = ERR_OVERRUN;
                        end else begin
                            data_s       = byte_s;
                            data_valid_s = 1'b1;
                            csum_s       = csum_update(csum_r, byte_s);
                            rem_s        = rem_r - BYTE_ONE;
                            if (rem_r == BYTE_ONE) begin
                                state_s = ST_CHK;
                            end else begin
                                state_s = ST_PAYLOAD;
                            end
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end

            ST_CHK: begin
                if (symb_tick) begin
                    shreg_s = byte_s;
                    if (byte_end_s) begin
                        bit_cnt_s    = {BW{1'b0}};
                        state_s      = ST_IDLE;
                        frame_done_s = 1'b1;
                        if (byte_s == csum_r) begin
                            frame_err_s = ERR_OK;
                        end else begin
                            frame_err_s = ERR_CSUM;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_s = ST_CHK;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_s      = ST_IDLE;
            data_valid_s = 1'b0;
            frame_done_s = 1'b0;
            frame_err_s  = frame_err_r;
            resync_s     = 1'b0;
            bit_cnt_s    = {BW{1'b0}};
            tmo_s        = {TW{1'b0}};
        end else begin
            state_s = state_s;
        end
    end

    // Datapath and output registers; correlator enables follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_r        <= {TW{1'b0}};
            bit_cnt_r    <= {BW{1'b0}};
            shreg_r      <= BYTE_ZERO;
            len_r        <= BYTE_ZERO;
            rem_r        <= BYTE_ZERO;
            csum_r       <= BYTE_ZERO;
            data_r       <= BYTE_ZERO;
            data_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= ERR_OK;
            resync_r     <= 1'b0;
            prm_en_r     <= 1'b0;
            sync_en_r    <= 1'b0;
        end else begin
            tmo_r        <= tmo_s;
            bit_cnt_r    <= bit_cnt_s;
            shreg_r      <= shreg_s;
            len_r        <= len_s;
            rem_r        <= rem_s;
            csum_r       <= csum_s;
            data_r       <= data_s;
            data_valid_r <= data_valid_s;
            frame_done_r <= frame_done_s;
            frame_err_r  <= frame_err_s;
            resync_r     <= resync_s;
            prm_en_r     <= (state_s == ST_IDLE);
            sync_en_r    <= (state_s == ST_HUNT);
        end
    end

endmodule

// File: tb/tb_ask_frame_ctrl.sv
// Scoreboard bench for ask_frame_ctrl: stimulus pushes expected payload
// bytes and frame_err codes into queues; a monitor pops and compares them
// whenever a byte transfer or a frame_done pulse appears.
module tb_ask_frame_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic abort = 1'b0;
    logic preamble_hit = 1'b0;
    logic sync_hit = 1'b0;
    logic symb_tick = 1'b0;
    logic bit_in = 1'b0;
    logic prm_en;
    logic sync_en;
    logic resync;

    ask_frame_ctrl_if #(.PACKLEN(8)) bus();

    ask_frame_ctrl #(
        .PACKLEN(8),
        .MAX_LEN(16),
        .SYNC_TIMEOUT(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .abort(abort),
        .preamble_hit(preamble_hit),
        .sync_hit(sync_hit),
        .symb_tick(symb_tick),
        .bit_in(bit_in),
        .prm_en(prm_en),
        .sync_en(sync_en),
        .resync(resync),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_data[$];
    logic [2:0] exp_err[$];
    logic [7:0] tx[$];

    // Monitor: every accepted byte and every frame_done is checked against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.data_valid && bus.data_ready) begin
                tests++;
                if (exp_data.size() == 0) begin
                    fails++;
                    $display("FAIL data_unexpected got %h want none", bus.data);
                end else begin
                    logic [7:0] e;
                    e = exp_data.pop_front();
                    if (bus.data !== e) begin
                        fails++;
                        $display("FAIL data_byte got %h want %h", bus.data, e);
                    end
                end
            end
            if (bus.frame_done) begin
                tests++;
                if (exp_err.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected got err %0d want no frame_done", bus.frame_err);
                end else begin
                    logic [2:0] e;
                    e = exp_err.pop_front();
                    if (bus.frame_err !== e) begin
                        fails++;
                        $display("FAIL frame_err got %0d want %0d", bus.frame_err, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pre();
        preamble_hit = 1'b1;
        cycle();
        preamble_hit = 1'b0;
        chk("resync_pulse", {31'd0, resync}, 32'd1);
        chk("sync_en_hunt", {30'd0, sync_en, prm_en}, 32'd2);
        cycle();
    endtask

    task automatic pulse_sync();
        sync_hit = 1'b1;
        cycle();
        sync_hit = 1'b0;
        cycle();
    endtask

    task automatic send_bit(input logic b);
        symb_tick = 1'b1;
        bit_in = b;
        cycle();
        symb_tick = 1'b0;
        bit_in = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic send_tx();
        logic [7:0] v;
        while (tx.size() != 0) begin
            v = tx.pop_front();
            for (int i = 7; i >= 0; i--) begin
                send_bit(v[i]);
            end
        end
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_data.size() != 0 || exp_err.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, exp_data.size() + exp_err.size(), 32'd0);
        exp_data.delete();
        exp_err.delete();
    endtask

    task automatic good_frame();
        exp_data.push_back(8'hAA);
        exp_data.push_back(8'h55);
        exp_data.push_back(8'h0F);
        exp_err.push_back(3'd0);
        tx = '{8'h03, 8'hAA, 8'h55, 8'h0F, 8'hF3};
        pulse_pre();
        pulse_sync();
        send_tx();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] cs;
        bus.data_ready = 1'b1;

        // Reset state
        repeat (3) cycle();
        chk("rst_outputs", {bus.data, bus.data_valid, bus.frame_done, bus.frame_err,
                            prm_en, sync_en, resync}, 32'd0);
        reset = 1'b1;
        cycle();
        chk("idle_prm_en", {30'd0, prm_en, sync_en}, 32'd2);

        // 1: good frame
        good_frame();
        drain("t1_drain");

        // 2: bad checksum
        exp_data.push_back(8'hAA);
        exp_data.push_back(8'h55);
        exp_data.push_back(8'h0F);
        exp_err.push_back(3'd3);
        tx = '{8'h03, 8'hAA, 8'h55, 8'h0F, 8'h00};
        pulse_pre();
        pulse_sync();
        send_tx();
        drain("t2_drain");

        // 3: sync timeout after 24 ticks
        exp_err.push_back(3'd1);
        pulse_pre();
        for (int i = 1; i <= 24; i++) begin
            symb_tick = 1'b1;
            cycle();
            symb_tick = 1'b0;
            if (i == 23) begin
                chk("t3_no_early_done", {31'd0, bus.frame_done}, 32'd0);
            end
            if (i == 24) begin
                chk("t3_done_err", {28'd0, bus.frame_done, bus.frame_err}, 32'd9);
                chk("t3_prm_en", {31'd0, prm_en}, 32'd1);
            end
            cycle();
            cycle();
        end
        drain("t3_drain");

        // 4: length boundaries
        exp_err.push_back(3'd2);
        tx = '{8'h00};
        pulse_pre();
        pulse_sync();
        send_tx();
        drain("t4_len0");
        exp_err.push_back(3'd2);
        tx = '{8'h11};
        pulse_pre();
        pulse_sync();
        send_tx();
        drain("t4_len17");
        cs = 8'h10;
        tx.push_back(8'h10);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 29 + 7);
            cs = cs ^ b;
            tx.push_back(b);
            exp_data.push_back(b);
        end
        tx.push_back(cs);
        exp_err.push_back(3'd0);
        pulse_pre();
        pulse_sync();
        send_tx();
        drain("t4_len16");

        // 5: overrun with consumer stalled, then a clean frame
        bus.data_ready = 1'b0;
        exp_err.push_back(3'd4);
        tx = '{8'h03, 8'hAA, 8'h55};
        pulse_pre();
        pulse_sync();
        send_tx();
        drain("t5_drain");
        chk("t5_valid_clear", {31'd0, bus.data_valid}, 32'd0);
        bus.data_ready = 1'b1;
        good_frame();
        drain("t5_clean");

        // 6a: asynchronous reset mid-payload
        exp_data.push_back(8'hAA);
        tx = '{8'h03, 8'hAA};
        pulse_pre();
        pulse_sync();
        send_tx();
        drain("t6_first_byte");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_rst", {bus.data, bus.data_valid, bus.frame_done, bus.frame_err,
                             prm_en, sync_en, resync}, 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        chk("t6_rst_idle", {30'd0, prm_en, sync_en}, 32'd2);

        // 6b: abort while hunting
        pulse_pre();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("t6_abort_idle", {29'd0, prm_en, sync_en, bus.frame_done}, 32'd4);
        repeat (5) cycle();
        drain("t6_abort_drain");
        good_frame();
        drain("t6_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
